fft_sched: RTL and testbench
============================

FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 The block SHALL have parameter IN_W, default 12, giving the sample width of I and Q.
REQ-002 The block SHALL have parameter FFT_LEN, default 256, giving the samples per frame; it SHALL be a power of two, at least 4.
REQ-003 The block SHALL have parameter TAG_DEPTH, default 4, giving the channel-tag FIFO depth; it SHALL be a power of two.
REQ-004 The block SHALL have port mclk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_init, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports i_vld0 and i_vld1, input, 1 bit each: requester 0/1 sample valid.
REQ-007 The block SHALL have ports o_rdy0 and o_rdy1, output, 1 bit each: requester 0/1 ready; a sample transfers on vld&rdy.
REQ-008 The block SHALL have ports i_I0, i_Q0, i_I1 and i_Q1, input, IN_W bits signed: requester samples.
REQ-009 The block SHALL have ports i_last0 and i_last1, input, 1 bit each: early end-of-frame marker, used only with the macro.
REQ-010 The block SHALL have ports o_vld (1 bit), o_I and o_Q (IN_W bits signed), outputs: the sample stream to the FFT pipeline.
REQ-011 The block SHALL have port i_new_fft, input, 1 bit: frame-start strobe from the FFT output.
REQ-012 The block SHALL have ports o_tag_vld (1 bit) and o_tag (1 bit), outputs: the source channel of the frame now leaving the FFT.
REQ-013 The block SHALL have port o_tag_err, output, 1 bit: strobe marking a tag underflow.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high while a frame is in progress.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PAD.
REQ-016 In IDLE, when the tag FIFO is not full and any i_vld is high, the block SHALL grant one channel and go to RUN the next cycle; it SHALL accept no sample in the grant cycle.
REQ-017 When both channels request together, the grant SHALL go to the channel not granted last; the first grant after reset goes to channel 0.
REQ-018 In RUN, o_rdy of the granted channel SHALL be 1; the other o_rdy SHALL be 0; both SHALL be 0 in IDLE and PAD.
REQ-019 Each accepted sample SHALL appear on o_I/o_Q with o_vld=1 exactly 1 cycle later; o_vld SHALL be 0 otherwise, so input gaps pass through as gaps.
REQ-020 A frame counter SHALL count accepted samples; on acceptance of sample FFT_LEN-1 the block SHALL push the granted channel id to the tag FIFO, clear the counter and return to IDLE.
REQ-021 A grant SHALL never change mid-frame; requester 1 SHALL wait for the rest of requester 0's frame even while requester 0 stalls.
REQ-022 In IDLE with the tag FIFO full, the block SHALL issue no grant.
REQ-023 In a cycle with i_new_fft=1 and the FIFO non-empty, o_tag_vld SHALL be 1 and o_tag SHALL equal the FIFO head, which is popped.
REQ-024 In a cycle with i_new_fft=1 and the FIFO empty, o_tag_err SHALL pulse 1 cycle, o_tag_vld SHALL be 0, and FIFO state SHALL be unchanged.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full or empty; occupancy is unchanged.
REQ-026 o_busy SHALL be 1 in RUN and PAD, and 0 in IDLE.

Reset
REQ-027 While i_init=1, the FSM SHALL be IDLE, the counter 0, the FIFO empty and last-grant set so channel 0 wins next.
REQ-028 While i_init=1, o_vld, o_rdy0, o_rdy1, o_tag_vld, o_tag_err and o_busy SHALL be 0, and o_I, o_Q and o_tag SHALL be 0.
REQ-029 Reset mid-frame SHALL drop the partial frame with no tag push; the first post-reset frame SHALL start from count 0.

Configuration
REQ-030 With macro FFT_SCHED_ZPAD_EN defined, an accepted sample with i_last=1 on the granted channel SHALL move the FSM to PAD when count < FFT_LEN-1.
REQ-031 In PAD, the block SHALL emit zero samples with o_vld=1 on consecutive cycles until FFT_LEN total, then push the tag and return to IDLE.
REQ-032 With FFT_SCHED_ZPAD_EN undefined, i_last0 and i_last1 SHALL be ignored and PAD SHALL be unreachable.

Verification
REQ-033 Bench: ch0 streams 256 samples continuously, FFT_LEN=256 -> o_vld for 256 cycles at latency 1, exactly 1 tag=0 pushed, then IDLE.
REQ-034 Bench: both channels request continuously -> grants alternate 0,1,0,1 per frame; on i_new_fft pulses o_tag reads 0,1,0,1.
REQ-035 Bench: ch0 drops vld for 10 cycles mid-frame while ch1 requests -> o_rdy1 stays 0 until ch0 frame sample 255 is accepted.
REQ-036 Bench: TAG_DEPTH=4, 4 frames sent with no i_new_fft -> 5th request not granted; one i_new_fft -> grant follows.
REQ-037 Bench: i_new_fft with FIFO empty -> o_tag_err 1 cycle, o_tag_vld 0.
REQ-038 Bench: macro defined, i_last0 on sample 99 -> 156 zero samples follow at o_vld=1, tag 0 pushed; macro undefined -> frame waits for 256 samples.

Source files
------------

// File: rtl/fft_sched.sv
// fft_sched -- two-requester frame scheduler in front of an FFT pipeline.
//
// Grants one of two sample requesters for a whole frame of FFT_LEN samples
// and forwards the accepted samples to the FFT with one cycle of latency.
// Arbitration between simultaneous requesters alternates frame by frame.
// At the end of each frame the source channel id is queued in a small tag
// FIFO. When the FFT output announces a new frame, that FIFO is popped so
// the downstream logic knows which channel the frame belongs to.
//
// Optional feature (macro FFT_SCHED_ZPAD_EN): an i_last marker on the
// granted channel ends the input early. The rest of the frame is then
// filled with zero samples. Without the macro, i_last0/i_last1 are ignored.
//
// Parameters:
//   IN_W      sample width of I and Q (signed)
//   FFT_LEN   samples per frame, power of two, >= 4
//   TAG_DEPTH tag FIFO depth, power of two
//
// Ports:
//   mclk               clock, rising edge
//   i_init             asynchronous active-high reset
//   i_vld0/1, o_rdy0/1 requester handshakes (transfer on vld & rdy)
//   i_I0/i_Q0/i_I1/i_Q1 requester samples
//   i_last0/1          early end-of-frame markers (zero-pad build only)
//   o_vld, o_I, o_Q    sample stream to the FFT
//   i_new_fft          frame-start strobe from the FFT output
//   o_tag_vld, o_tag   channel of the frame now leaving the FFT
//   o_tag_err          strobe: new_fft arrived with no tag queued
//   o_busy             a frame is being collected or padded
module fft_sched #(
  parameter int IN_W      = 12,
  parameter int FFT_LEN   = 256,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   mclk,
  input  logic                   i_init,
  input  logic                   i_vld0,
  input  logic                   i_vld1,
  output logic                   o_rdy0,
  output logic                   o_rdy1,
  input  logic signed [IN_W-1:0] i_I0,
  input  logic signed [IN_W-1:0] i_Q0,
  input  logic signed [IN_W-1:0] i_I1,
  input  logic signed [IN_W-1:0] i_Q1,
  input  logic                   i_last0,
  input  logic                   i_last1,
  output logic                   o_vld,
  output logic signed [IN_W-1:0] o_I,
  output logic signed [IN_W-1:0] o_Q,
  input  logic                   i_new_fft,
  output logic                   o_tag_vld,
  output logic                   o_tag,
  output logic                   o_tag_err,
  output logic                   o_busy
);

  localparam int CW = $clog2(FFT_LEN);
  // A depth-1 FIFO still gets a 1-bit address. Capacity is enforced by the
  // occupancy count, not by the address width.
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  state_t                 state, state_nxt;
  logic                   grant, grant_nxt;
  logic [CW-1:0]          count, count_nxt;
  logic                   accept, push, pop;
  logic                   sel_vld;
  logic signed [IN_W-1:0] sel_I, sel_Q;

  logic                   tag_mem [0:2**AW-1];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [OW-1:0]          occ;
  logic                   tag_full, tag_empty, head;

`ifdef FFT_SCHED_ZPAD_EN
  logic sel_last;
  assign sel_last = grant ? i_last1 : i_last0;
`else
  logic unused_last;
  assign unused_last = i_last0 ^ i_last1;
`endif

  assign sel_vld = grant ? i_vld1 : i_vld0;
  assign sel_I   = grant ? i_I1 : i_I0;
  assign sel_Q   = grant ? i_Q1 : i_Q0;

  assign tag_full  = (occ == OW'(TAG_DEPTH));
  assign tag_empty = (occ == '0);

  // Forward the tag being pushed when the FIFO is empty. This lets a
  // simultaneous push and pop on an empty FIFO both take effect.
  assign head      = tag_empty ? grant : tag_mem[rd_ptr];
  assign pop       = i_new_fft && (!tag_empty || push);
  assign o_tag_vld = pop;
  assign o_tag     = pop && head;
  assign o_tag_err = i_new_fft && tag_empty && !push && !i_init;
  assign o_busy    = (state != IDLE);

  // State register. After reset, 'grant' holds "last granted" as channel 1,
  // so channel 0 wins the first tie.
  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      state <= IDLE;
      grant <= 1'b1;
      count <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      count <= count_nxt;
    end
  end

  // Arbitration, frame counting and end-of-frame tag push. The grant only
  // moves in IDLE, so a stalled owner keeps the other channel waiting.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    count_nxt = count;
    accept    = 1'b0;
    push      = 1'b0;
    o_rdy0    = 1'b0;
    o_rdy1    = 1'b0;
    case (state)
      IDLE: begin
        if (!tag_full && (i_vld0 || i_vld1)) begin
          grant_nxt = (i_vld0 && i_vld1) ? ~grant : i_vld1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        o_rdy0 = ~grant;
        o_rdy1 = grant;
        accept = sel_vld;
        if (sel_vld) begin
          if (count == LAST_IDX) begin
            push      = 1'b1;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + 1'b1;
`ifdef FFT_SCHED_ZPAD_EN
            if (sel_last) state_nxt = PAD;
`endif
          end
        end
      end
      PAD: begin
        if (count == LAST_IDX) begin
          push      = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: one cycle of latency for accepted samples. PAD inserts
  // zero samples. Idle cycles drive zeros with o_vld low.
  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      o_vld <= 1'b0;
      o_I   <= '0;
      o_Q   <= '0;
    end else if (accept) begin
      o_vld <= 1'b1;
      o_I   <= sel_I;
      o_Q   <= sel_Q;
    end else begin
      o_vld <= (state == PAD);
      o_I   <= '0;
      o_Q   <= '0;
    end
  end

  // Tag FIFO storage. No reset is needed, because occupancy qualifies every
  // read. A push never meets a full FIFO without a pop: grants are withheld
  // while full.
  always_ff @(posedge mclk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched -- randomized self-checking bench for fft_sched.
//
// A frame-level reference model tracks frame ownership, samples collected,
// padding, the alternating tie-break and a queue of pending tags. It
// predicts the handshakes, the output stream and the tag port every cycle.
// Directed phases cover single-channel streaming, alternating grants, owner
// stalls, a full tag FIFO, tag underflow, early end of frame (zero-pad
// build or plain build), mid-frame reset and a random soak.
module tb_fft_sched;

  localparam int IN_W      = 12;
  localparam int FFT_LEN   = 256;
  localparam int TAG_DEPTH = 4;
`ifdef FFT_SCHED_ZPAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  logic mclk = 1'b0;
  logic i_init = 1'b1;
  logic i_vld0 = 1'b0, i_vld1 = 1'b0, i_last0 = 1'b0, i_last1 = 1'b0, i_new_fft = 1'b0;
  logic signed [IN_W-1:0] i_I0 = '0, i_Q0 = '0, i_I1 = '0, i_Q1 = '0;
  logic o_rdy0, o_rdy1, o_vld, o_tag_vld, o_tag, o_tag_err, o_busy;
  logic signed [IN_W-1:0] o_I, o_Q;

  fft_sched #(.IN_W(IN_W), .FFT_LEN(FFT_LEN), .TAG_DEPTH(TAG_DEPTH)) dut (
    .mclk(mclk), .i_init(i_init),
    .i_vld0(i_vld0), .i_vld1(i_vld1), .o_rdy0(o_rdy0), .o_rdy1(o_rdy1),
    .i_I0(i_I0), .i_Q0(i_Q0), .i_I1(i_I1), .i_Q1(i_Q1),
    .i_last0(i_last0), .i_last1(i_last1),
    .o_vld(o_vld), .o_I(o_I), .o_Q(o_Q),
    .i_new_fft(i_new_fft), .o_tag_vld(o_tag_vld), .o_tag(o_tag),
    .o_tag_err(o_tag_err), .o_busy(o_busy)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_in_frame, m_padding, m_owner, m_prev;
  int m_filled;
  bit m_tagq[$];
  bit exp_vld;
  int exp_i, exp_q;

  // Observation helpers
  int vld_seen;
  bit obs_tags[$];

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_in_frame = 1'b0;
    m_padding  = 1'b0;
    m_owner    = 1'b0;
    m_prev     = 1'b1;
    m_filled   = 0;
    m_tagq.delete();
    exp_vld = 1'b0;
    exp_i   = 0;
    exp_q   = 0;
  endtask

  task automatic applyReset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge mclk);
      i_init    = 1'b1;
      i_vld0    = 1'($urandom);
      i_vld1    = 1'($urandom);
      i_new_fft = 1'b1;
      #1;
      checkOutput("rst_o_vld", o_vld, 0);
      checkOutput("rst_o_I", o_I, 0);
      checkOutput("rst_o_Q", o_Q, 0);
      checkOutput("rst_rdy0", o_rdy0, 0);
      checkOutput("rst_rdy1", o_rdy1, 0);
      checkOutput("rst_tag_vld", o_tag_vld, 0);
      checkOutput("rst_tag", o_tag, 0);
      checkOutput("rst_tag_err", o_tag_err, 0);
      checkOutput("rst_busy", o_busy, 0);
      modelReset();
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus(input bit v0, input bit v1, input bit l0, input bit l1,
                               input bit nf);
    bit acc, push, g_ok, vsel, lsel;
    bit e_rdy0, e_rdy1, e_tv, e_tag, e_err;
    logic signed [IN_W-1:0] si, sq;
    @(negedge mclk);
    i_init    = 1'b0;
    i_vld0    = v0;
    i_vld1    = v1;
    i_last0   = l0;
    i_last1   = l1;
    i_new_fft = nf;
    i_I0 = IN_W'($urandom);
    i_Q0 = IN_W'($urandom);
    i_I1 = IN_W'($urandom);
    i_Q1 = IN_W'($urandom);
    #1;
    checkOutput("o_vld", o_vld, exp_vld);
    checkOutput("o_I", o_I, exp_i);
    checkOutput("o_Q", o_Q, exp_q);
    if (o_vld === 1'b1) vld_seen++;

    e_rdy0 = m_in_frame && !m_padding && !m_owner;
    e_rdy1 = m_in_frame && !m_padding && m_owner;
    checkOutput("rdy0", o_rdy0, e_rdy0);
    checkOutput("rdy1", o_rdy1, e_rdy1);
    checkOutput("busy", o_busy, m_in_frame);

    vsel = m_owner ? v1 : v0;
    lsel = m_owner ? l1 : l0;
    si   = m_owner ? i_I1 : i_I0;
    sq   = m_owner ? i_Q1 : i_Q0;
    acc  = m_in_frame && !m_padding && vsel;
    push = m_in_frame && (acc || m_padding) && (m_filled == FFT_LEN - 1);
    g_ok = !m_in_frame && (m_tagq.size() < TAG_DEPTH) && (v0 || v1);

    exp_vld = acc || m_padding;
    exp_i   = acc ? int'(si) : 0;
    exp_q   = acc ? int'(sq) : 0;

    if (acc || m_padding) m_filled++;
    if (push) begin
      m_tagq.push_back(m_owner);
      m_in_frame = 1'b0;
      m_padding  = 1'b0;
      m_filled   = 0;
    end else if (acc && lsel && ZPAD) begin
      m_padding = 1'b1;
    end
    if (g_ok) begin
      m_owner    = (v0 && v1) ? !m_prev : v1;
      m_prev     = m_owner;
      m_in_frame = 1'b1;
      m_filled   = 0;
    end

    e_tv = 1'b0; e_tag = 1'b0; e_err = 1'b0;
    if (nf) begin
      if (m_tagq.size() > 0) begin
        e_tv  = 1'b1;
        e_tag = m_tagq.pop_front();
      end else begin
        e_err = 1'b1;
      end
    end
    checkOutput("tag_vld", o_tag_vld, e_tv);
    checkOutput("tag_err", o_tag_err, e_err);
    if (e_tv) checkOutput("tag", o_tag, e_tag);
    if (o_tag_vld === 1'b1) obs_tags.push_back(o_tag);
  endtask

  initial begin
    modelReset();
    applyReset(3);

    // Single channel streams one full frame, then the tag is popped.
    vld_seen = 0;
    for (int c = 0; c < FFT_LEN + 1; c++) applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stream_vld_count", vld_seen, FFT_LEN);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("stream_tag", o_tag, 0);
    // Underflow on an empty FIFO
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("err_empty", o_tag_err, 1);
    checkOutput("err_tag_vld", o_tag_vld, 0);

    // Both channels request: grants alternate, tags read 0,1,0,1.
    applyReset(2);
    obs_tags.delete();
    for (int c = 0; c < 4 * (FFT_LEN + 1) + 4; c++)
      applyStimulus(c < 4 * (FFT_LEN + 1), c < 4 * (FFT_LEN + 1), 0, 0, m_tagq.size() > 0);
    checkOutput("alt_tag_count", obs_tags.size(), 4);
    for (int k = 0; k < 4 && k < obs_tags.size(); k++)
      checkOutput($sformatf("alt_tag%0d", k), obs_tags[k], k % 2);

    // Owner stalls mid-frame (with a 10-cycle drop) while channel 1 waits.
    applyReset(2);
    for (int c = 0; c < 2 * (FFT_LEN + 1) + 60; c++)
      applyStimulus(!(c >= 120 && c < 130) && ($urandom_range(3) != 0), 1, 0, 0,
                    m_tagq.size() > 0);

    // Tag FIFO fills up: no grant until one tag is popped.
    applyReset(2);
    for (int c = 0; c < TAG_DEPTH * (FFT_LEN + 1) + 30; c++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("full_no_grant", o_busy, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("grant_after_pop", o_busy, 1);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, m_tagq.size() > 0);

    // Early end of frame on sample 99, then a long input gap.
    applyReset(2);
    vld_seen = 0;
    for (int c = 0; c < 700; c++) begin
      applyStimulus((c <= 100) || (c >= 300), 0, c == 100, 0, c == 290);
      if (c == 280) checkOutput("zpad_busy", o_busy, ZPAD ? 0 : 1);
      if (c == 290) begin
        checkOutput("zpad_vld_count", vld_seen, ZPAD ? FFT_LEN : 100);
        checkOutput("zpad_tag_vld", o_tag_vld, ZPAD ? 1 : 0);
      end
    end

    // Reset in the middle of a frame drops it; the next frame starts clean.
    applyReset(2);
    for (int c = 0; c < 50; c++) applyStimulus(1, 0, 0, 0, 0);
    applyReset(3);
    for (int c = 0; c < FFT_LEN + 1; c++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("post_rst_tag_vld", o_tag_vld, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("post_rst_single_tag", o_tag_err, 1);

    // Random soak
    applyReset(2);
    for (int c = 0; c < 3000; c++)
      applyStimulus($urandom_range(3) != 0, $urandom_range(3) != 0,
                    $urandom_range(63) == 0, $urandom_range(63) == 0,
                    $urandom_range(99) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
